// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor.
// Computes diff = in1 - in2 - bin, LSB first, one bit per clock.
// Operands are captured on a start/done handshake.
//
// Handshake: start is accepted on any rising edge where the block is not
// busy (IDLE or DONE). An accepted start latches in1/in2/bin. The result
// appears WIDTH edges later. It is marked by a one-cycle done pulse.
// diff/bout change only on entry to DONE and otherwise hold their value.
//
// Optional build macro SERIAL_SUB_OVF_EN adds the ovf output, which
// reports signed overflow of the subtraction.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Holds the WIDTH-1 result bits already produced. The final bit is
    // merged in directly when diff is loaded.
    logic [WIDTH-2:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current operand LSBs and the running borrow.
    always_comb begin
        d_bit     = a_q[0] ^ b_q[0] ^ br_q;
        br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_shift = {d_bit, res_q};
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and the datapath.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = in1;
                    b_d     = in2;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = in1[WIDTH-1];
                    b_msb_d = in2[WIDTH-1];
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = res_shift[WIDTH-1:1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    diff_d  = res_shift;
                    bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Status and result outputs decode directly from registers.
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
        diff = diff_q;
        bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf  = ovf_q;
`endif
    end

endmodule
